// File: rtl/prince_sbox_cms_compress.sv
// ---------------------------------------------------------------------------
// prince_sbox_cms_compress
//
// Register-and-compression layer behind the PRINCE CMS S-box component
// functions. Each S-box output bit arrives as NB_INTER intermediate shares.
// They are ring-refreshed with fresh randomness and registered in stage 1,
// which is the glitch/non-completeness barrier. Stage 2 XOR-compresses them
// down to NB_OUT shares per bit. Valid/ready flow control lets the S-box
// pipeline stall without losing or duplicating vectors.
//
// Optional build macro: PRINCE_CMS_STARVE_CNT_EN
//   defined   -> starve_cnt counts cycles where a vector was offered and the
//                block was ready, but no randomness was available. It
//                saturates at 8'hFF and is cleared only by reset.
//   undefined -> starve_cnt is tied to 8'h00.
//   The datapath is the same in both builds.
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   in_valid/in_ready     intermediate-share handshake
//   in_data               share k of bit b at index b*NB_INTER+k
//   rnd_valid/rnd_ready   refresh randomness; rnd_ready pulses on consumption
//   rnd_data              randomness, same indexing as in_data
//   out_valid/out_ready   compressed-share handshake
//   out_data              share j of bit b at index b*NB_OUT+j
//   starve_cnt            randomness-starvation counter
// ---------------------------------------------------------------------------
module prince_sbox_cms_compress #(
    parameter int unsigned NB_BITS  = 4,
    parameter int unsigned NB_INTER = 8,
    parameter int unsigned NB_OUT   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NB_BITS*NB_INTER-1:0]  in_data,
    input  logic                         rnd_valid,
    output logic                         rnd_ready,
    input  logic [NB_BITS*NB_INTER-1:0]  rnd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NB_BITS*NB_OUT-1:0]    out_data,
    output logic [7:0]                   starve_cnt
);

    localparam int unsigned InW  = NB_BITS * NB_INTER;
    localparam int unsigned OutW = NB_BITS * NB_OUT;

    // Elaboration-time parameter sanity.
    if (NB_INTER < 2) begin : g_chk_inter
        $error("NB_INTER must be at least 2");
    end
    if ((NB_INTER % NB_OUT) != 0) begin : g_chk_div
        $error("NB_INTER must be a multiple of NB_OUT");
    end

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    logic            s1_valid_q, s1_valid_d;
    logic [InW-1:0]  s1_data_q;
    logic            s2_valid_q, s2_valid_d;
    logic [OutW-1:0] s2_data_q;

    logic            accept;
    logic            advance;
    logic [InW-1:0]  refreshed;
    logic [OutW-1:0] compressed;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    // Stage 1 moves on whenever stage 2 is empty or draining this cycle.
    assign advance = s1_valid_q & (~s2_valid_q | out_ready);

    // Only depends on registered state and out_ready, so an upstream valid
    // can never loop back into its own ready.
    assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;

    // Data and randomness are consumed together or not at all.
    assign accept    = in_valid & in_ready & rnd_valid;
    assign rnd_ready = accept;

    // -----------------------------------------------------------------------
    // Ring refresh: every r[b][k] is XORed into shares k and k+1 (mod
    // NB_INTER), so the XOR of all shares of a bit is preserved.
    // -----------------------------------------------------------------------
    always_comb begin : ring_refresh
        refreshed = '0;
        for (int unsigned b = 0; b < NB_BITS; b++) begin
            for (int unsigned k = 0; k < NB_INTER; k++) begin
                refreshed[b*NB_INTER + k] =
                    in_data[b*NB_INTER + k] ^
                    rnd_data[b*NB_INTER + k] ^
                    rnd_data[b*NB_INTER + ((k + NB_INTER - 1) % NB_INTER)];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Compression: share k of a bit folds into output share k mod NB_OUT.
    // Fed only from the stage-1 register, never from the inputs.
    // -----------------------------------------------------------------------
    always_comb begin : compress
        compressed = '0;
        for (int unsigned b = 0; b < NB_BITS; b++) begin
            for (int unsigned k = 0; k < NB_INTER; k++) begin
                compressed[b*NB_OUT + (k % NB_OUT)] =
                    compressed[b*NB_OUT + (k % NB_OUT)] ^ s1_data_q[b*NB_INTER + k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Valid next-state
    // -----------------------------------------------------------------------
    always_comb begin : valid_next
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;

        // A fill in the same cycle as a drain keeps stage 1 occupied.
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        if (advance) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin : stage_regs
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                s1_data_q <= refreshed;
            end
            // Output shares change only on a stage-2 load and otherwise hold,
            // including after out_valid drops.
            if (advance) begin
                s2_data_q <= compressed;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

    // -----------------------------------------------------------------------
    // Randomness starvation counter
    // -----------------------------------------------------------------------
`ifdef PRINCE_CMS_STARVE_CNT_EN
    logic [7:0] starve_cnt_q;
    logic       starve_event;

    assign starve_event = in_valid & in_ready & ~rnd_valid;

    always_ff @(posedge clk or negedge rst_n) begin : starve_reg
        if (!rst_n) begin
            starve_cnt_q <= 8'h00;
        end else if (starve_event && (starve_cnt_q != 8'hFF)) begin
            starve_cnt_q <= starve_cnt_q + 8'd1;
        end
    end

    assign starve_cnt = starve_cnt_q;
`else
    assign starve_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_prince_sbox_cms_compress.sv
// ---------------------------------------------------------------------------
// Self-checking bench for prince_sbox_cms_compress.
// A behavioural model predicts each cycle's outputs: accepted vectors sit in
// a queue (at most two in flight), the head becomes visible two cycles after
// its accept, and its expected shares are computed straight from the
// refresh/compress equations. Literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_prince_sbox_cms_compress;

    localparam int NB_BITS  = 4;
    localparam int NB_INTER = 8;
    localparam int NB_OUT   = 2;
    localparam int IW       = NB_BITS * NB_INTER;
    localparam int OW       = NB_BITS * NB_OUT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          rnd_valid = 1'b0;
    logic          rnd_ready;
    logic [IW-1:0] rnd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic [7:0]    starve_cnt;

    always #5 clk = ~clk;

    prince_sbox_cms_compress #(
        .NB_BITS  (NB_BITS),
        .NB_INTER (NB_INTER),
        .NB_OUT   (NB_OUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .starve_cnt (starve_cnt)
    );

    // ---------------- model state ----------------
    typedef struct {
        int                 acc;
        logic [OW-1:0]      exp;
        logic [NB_BITS-1:0] par;
    } item_t;

    item_t         q[$];
    logic [OW-1:0] last_out = '0;
    int            starve_exp = 0;
    int            cyc = 0;
    bit            acc_flag;

    int checks = 0;
    int failures = 0;

    // Refresh then compress, computed share by share.
    function automatic logic [OW-1:0] model_out(logic [IW-1:0] d, logic [IW-1:0] r);
        logic [OW-1:0] o;
        logic          sh;
        o = '0;
        for (int b = 0; b < NB_BITS; b++) begin
            for (int k = 0; k < NB_INTER; k++) begin
                sh = d[b*NB_INTER + k] ^ r[b*NB_INTER + k]
                     ^ r[b*NB_INTER + ((k + NB_INTER - 1) % NB_INTER)];
                o[b*NB_OUT + (k % NB_OUT)] = o[b*NB_OUT + (k % NB_OUT)] ^ sh;
            end
        end
        return o;
    endfunction

    function automatic logic [NB_BITS-1:0] in_parity(logic [IW-1:0] d);
        logic [NB_BITS-1:0] p;
        p = '0;
        for (int b = 0; b < NB_BITS; b++)
            for (int k = 0; k < NB_INTER; k++)
                p[b] = p[b] ^ d[b*NB_INTER + k];
        return p;
    endfunction

    function automatic logic [NB_BITS-1:0] out_parity(logic [OW-1:0] o);
        logic [NB_BITS-1:0] p;
        p = '0;
        for (int b = 0; b < NB_BITS; b++)
            for (int j = 0; j < NB_OUT; j++)
                p[b] = p[b] ^ o[b*NB_OUT + j];
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance
    // the model by what the edge should do. Entered and left at posedge+1.
    task automatic step(input bit iv, input bit rv, input bit ordy,
                        input logic [IW-1:0] d, input logic [IW-1:0] r);
        bit exp_valid, exp_ready, exp_acc;
        in_valid  = iv;
        rnd_valid = rv;
        out_ready = ordy;
        in_data   = d;
        rnd_data  = r;
        #1;
        exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
        exp_ready = (q.size() < 2) || ordy;
        exp_acc   = iv && rv && exp_ready;
        chk("out_valid", out_valid, exp_valid);
        chk("out_data", out_data, exp_valid ? q[0].exp : last_out);
        chk("in_ready", in_ready, exp_ready);
        chk("rnd_ready", rnd_ready, exp_acc);
        chk("starve_cnt", starve_cnt, starve_exp);
        if (exp_valid && ordy)
            chk("share_parity", out_parity(out_data), q[0].par);
        @(posedge clk);
        if (exp_valid && ordy) begin
            last_out = q[0].exp;
            void'(q.pop_front());
        end
        if (exp_acc)
            q.push_back('{acc: cyc, exp: model_out(d, r), par: in_parity(d)});
`ifdef PRINCE_CMS_STARVE_CNT_EN
        if (iv && exp_ready && !rv && starve_exp < 255)
            starve_exp++;
`endif
        acc_flag = exp_acc;
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] d, r;
        bit            iv, rv, ordy, hold;
        int            acc_n;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rnd_ready", rnd_ready, 1'b0);
        chk("rst_starve", starve_cnt, 8'h00);

        // Pin the model against hand-computed values.
        chk("model_plain", model_out(32'h1, 32'h0), 8'h01);
        chk("model_refresh", model_out(32'h1, 32'h1), 8'h02);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Starvation for 5 cycles, then randomness arrives.
        repeat (5) step(1'b1, 1'b0, 1'b1, 32'hA5A5_0F0F, 32'h0);
`ifdef PRINCE_CMS_STARVE_CNT_EN
        chk("starve_5", starve_cnt, 8'd5);
`else
        chk("starve_5", starve_cnt, 8'd0);
`endif
        step(1'b1, 1'b1, 1'b1, 32'hA5A5_0F0F, 32'h1234_5678);
        repeat (3) step(1'b0, 1'b0, 1'b1, '0, '0);

        // Directed: single share set, no randomness.
        step(1'b1, 1'b1, 1'b1, 32'h1, 32'h0);
        step(1'b0, 1'b0, 1'b1, '0, '0);
        chk("lit_plain_valid", out_valid, 1'b1);
        chk("lit_plain_data", out_data, 8'h01);
        step(1'b0, 1'b0, 1'b1, '0, '0);

        // Directed: same input with refresh bit 0 set.
        step(1'b1, 1'b1, 1'b1, 32'h1, 32'h1);
        step(1'b0, 1'b0, 1'b1, '0, '0);
        chk("lit_refresh_data", out_data, 8'h02);
        step(1'b0, 1'b0, 1'b1, '0, '0);
        // Held after out_valid drops.
        chk("lit_hold_data", out_data, 8'h02);

        // Random stream with random backpressure; producer holds data
        // while not accepted.
        acc_n = 0;
        hold  = 1'b0;
        d     = '0;
        for (int i = 0; i < 400 && acc_n < 20; i++) begin
            if (!hold) d = $urandom();
            r    = $urandom();
            iv   = hold || ($urandom_range(3) != 0);
            rv   = ($urandom_range(3) != 0);
            ordy = ($urandom_range(1) != 0);
            step(iv, rv, ordy, d, r);
            hold = iv && !acc_flag;
            if (acc_flag) acc_n++;
        end
        chk("stream_accepts", acc_n >= 16, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1, '0, '0);

        // Long starvation: counter saturates when enabled.
        repeat (300) step(1'b1, 1'b0, 1'b1, 32'hFFFF_0000, '0);
`ifdef PRINCE_CMS_STARVE_CNT_EN
        chk("starve_sat", starve_cnt, 8'hFF);
`else
        chk("starve_sat", starve_cnt, 8'h00);
`endif

        // Fill both stages under backpressure, then reset mid-operation.
        step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        step(1'b1, 1'b1, 1'b0, 32'h1357_9BDF, 32'h2468_ACE0);
        step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        chk("full_in_ready", in_ready, 1'b0);
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_out_data", out_data, '0);
        chk("async_in_ready", in_ready, 1'b1);
        chk("async_rnd_ready", rnd_ready, 1'b0);
        chk("async_starve", starve_cnt, 8'h00);
        q.delete();
        last_out   = '0;
        starve_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1, '0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h8000_0001, 32'h4000_0002);
        step(1'b0, 1'b0, 1'b1, '0, '0);
        chk("post_rst_latency", out_valid, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prince_sbox_cms_compress.md
Name: prince_sbox_cms_compress

Overview:
Register-and-compression layer directly downstream of the PRINCE CMS S-box component functions. It takes the NB_INTER intermediate shares that each component function produces per S-box output bit and ring-refreshes them with fresh randomness. The refreshed shares are registered as the non-completeness/glitch barrier. A second registered stage then XOR-compresses them down to NB_OUT output shares per bit. Valid/ready flow control allows the S-box pipeline to stall cleanly.

Parameters:
NB_BITS, 4, S-box output bits handled (PRINCE nibble)
NB_INTER, 8, intermediate shares per output bit; must be a multiple of NB_OUT, >= 2
NB_OUT, 2, output shares per bit after compression

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  intermediate-share vector valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  NB_BITS*NB_INTER  intermediate shares; bit index b*NB_INTER+k = share k of output bit b
rnd_valid  input  1  fresh randomness available
rnd_ready  output  1  randomness consumed this cycle
rnd_data  input  NB_BITS*NB_INTER  refresh randomness, same indexing as in_data
out_valid  output  1  compressed shares valid
out_ready  input  1  downstream accepts out_data
out_data  output  NB_BITS*NB_OUT  output shares; index b*NB_OUT+j = share j of bit b
starve_cnt  output  8  randomness-starvation counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, stage-1/stage-2 data regs=0. Outputs: out_valid=0, out_data=0, in_ready=1, rnd_ready=0, starve_cnt=0.
- Ring refresh, per bit b, per k: ref[b][k] = in[b][k] ^ r[b][k] ^ r[b][(k-1) mod NB_INTER]. Each r appears twice, so the XOR of all shares of bit b is unchanged.
- Stage 1 register: captures ref on accept. accept = in_valid & in_ready & rnd_valid.
- rnd_ready = accept: randomness is consumed only together with data, never reused, never dropped.
- Stage 2 register: out[b][j] = XOR of s1[b][k] over all k with k mod NB_OUT == j. Stage 1 advances into stage 2 when s1_valid & (!s2_valid | out_ready).
- Latency: exactly 2 cycles from accept to out_valid with no stall. Throughput 1 vector/cycle.
- in_ready = !s1_valid | !s2_valid | out_ready. Combinational from out_ready only, never from in_valid or rnd_valid.
- Stall: out_valid & !out_ready holds out_data and s1 stable. A new accept is blocked only when both stages are full.
- in_valid=1 with rnd_valid=0: no accept, in_data is not captured, and the upstream producer must hold in_data.
- Simultaneous stage-2 drain and stage-1 fill in one cycle is allowed; no bubble.
- out_data holds its last value after out_valid drops. It updates only on stage-2 load.
- rst_n asserted mid-operation: in-flight vectors are discarded and no partial output is presented after release.
- No combinational path from in_data or rnd_data to out_data. Stage 1 must be a full register, never bypassed.

Optional Feature:
Macro PRINCE_CMS_STARVE_CNT_EN.
- Defined: starve_cnt increments each cycle with in_valid & in_ready & !rnd_valid. It saturates at 8'hFF and is cleared only by reset.
- Undefined: starve_cnt is tied to 8'h00 and no counter logic is generated. Datapath behaviour is identical in both builds.

Test Plan:
- Defaults, bit0 in_data[7:0]=8'h01, rnd_data=0, valid all, out_ready=1 -> 2 cycles later out_data[1:0]=2'b01, other bits 0.
- Same input with rnd_data[7:0]=8'h01 -> out_data[1:0]=2'b10. XOR of shares is still 1 and rnd_ready=1 for exactly the accept cycle.
- Streaming 16 random vectors with out_ready toggled randomly -> per-bit XOR of out shares equals per-bit XOR of in shares. Order is preserved, nothing is lost or duplicated, and in_ready=0 only while both stages are full.
- in_valid=1, rnd_valid=0 for 5 cycles, then 1 -> no accept for 5 cycles; starve_cnt=5 with PRINCE_CMS_STARVE_CNT_EN, 0 without.
- Starvation held 300 cycles with macro defined -> starve_cnt saturates at 8'hFF.
- rst_n pulsed low while s1 and s2 are full -> out_valid=0 and out_data=0 immediately (async). The next output appears 2 cycles after the next accept.
